// File: rtl/multicycle_controller.sv
// Moore control FSM for a multicycle RV32I-subset datapath (loads, stores, ALU ops, branches, jal).
// Define BRANCH_EXT_EN to evaluate branch conditions by funct3; without it every branch uses Zero.
module multicycle_controller #(
  parameter int ALU_CTRL_W = 3,
  parameter int MEM_HS     = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           Instr,
  input  logic                  Zero,
  input  logic                  Negative,
  input  logic                  Overflow,
  input  logic                  Carry,
  input  logic                  mem_ready,
  output logic                  PCWrite,
  output logic                  AdrSrc,
  output logic                  MemWrite,
  output logic                  IRWrite,
  output logic                  RegWrite,
  output logic [1:0]            ResultSrc,
  output logic [1:0]            ALUSrcA,
  output logic [1:0]            ALUSrcB,
  output logic [1:0]            ImmSrc,
  output logic [ALU_CTRL_W-1:0] ALUControl,
  output logic [3:0]            state_o,
  output logic                  illegal
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [ALU_CTRL_W-1:0] ALU_ADD = ALU_CTRL_W'(3'b000);
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB = ALU_CTRL_W'(3'b001);
  localparam logic [ALU_CTRL_W-1:0] ALU_AND = ALU_CTRL_W'(3'b010);
  localparam logic [ALU_CTRL_W-1:0] ALU_OR  = ALU_CTRL_W'(3'b011);
  localparam logic [ALU_CTRL_W-1:0] ALU_SLT = ALU_CTRL_W'(3'b101);

  state_t                  state_q, state_d;
  logic                    adr_src_q;
  logic [1:0]              result_src_q;
  logic [1:0]              alu_src_a_q;
  logic [1:0]              alu_src_b_q;
  logic [ALU_CTRL_W-1:0]   alu_ctrl_q;
  logic                    reg_write_q;
  logic                    mem_write_q;
  logic                    illegal_q;

  logic [6:0]              opcode;
  logic [2:0]              funct3;
  logic                    mem_ok;
  logic                    alu_legal;
  logic [ALU_CTRL_W-1:0]   alu_dec;
  logic                    branch_taken;
  logic                    branch_trap;
  logic                    unused_instr;

  assign opcode       = Instr[6:0];
  assign funct3       = Instr[14:12];
  assign mem_ok       = (MEM_HS != 0) ? mem_ready : 1'b1;
  assign unused_instr = ^{Instr[31], Instr[29:15], Instr[11:7]};

  always_comb begin
    alu_legal = 1'b1;
    alu_dec   = ALU_ADD;
    case (funct3)
      3'b000:  alu_dec = (opcode == OP_RTYPE && Instr[30]) ? ALU_SUB : ALU_ADD;
      3'b010:  alu_dec = ALU_SLT;
      3'b110:  alu_dec = ALU_OR;
      3'b111:  alu_dec = ALU_AND;
      default: alu_legal = 1'b0;
    endcase
  end

`ifdef BRANCH_EXT_EN
  always_comb begin
    branch_taken = 1'b0;
    branch_trap  = 1'b0;
    case (funct3)
      3'b000:  branch_taken = Zero;
      3'b001:  branch_taken = ~Zero;
      3'b100:  branch_taken = Negative ^ Overflow;
      3'b101:  branch_taken = ~(Negative ^ Overflow);
      3'b110:  branch_taken = ~Carry;
      3'b111:  branch_taken = Carry;
      default: branch_trap  = 1'b1;
    endcase
  end
`else
  logic unused_flags;
  assign unused_flags = ^{Negative, Overflow, Carry};
  assign branch_taken = Zero;
  assign branch_trap  = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem_ok) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEMADR:   state_d = Instr[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ok) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mem_ok) state_d = S_FETCH;
      S_EXECR,
      S_EXECI:    state_d = alu_legal ? S_ALUWB : S_TRAP;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = branch_trap ? S_TRAP : S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      default:    state_d = S_TRAP;
    endcase
  end

  // Output registers are loaded from the state being entered so they line up with state_q.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_FETCH;
      adr_src_q    <= 1'b0;
      result_src_q <= 2'b10;
      alu_src_a_q  <= 2'b00;
      alu_src_b_q  <= 2'b10;
      alu_ctrl_q   <= ALU_ADD;
      reg_write_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      adr_src_q    <= 1'b0;
      result_src_q <= 2'b00;
      alu_src_a_q  <= 2'b00;
      alu_src_b_q  <= 2'b00;
      alu_ctrl_q   <= ALU_ADD;
      reg_write_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      illegal_q    <= 1'b0;
      case (state_d)
        S_FETCH: begin
          result_src_q <= 2'b10;
          alu_src_b_q  <= 2'b10;
        end
        S_DECODE: begin
          alu_src_a_q <= 2'b01;
          alu_src_b_q <= 2'b01;
        end
        S_MEMADR: begin
          alu_src_a_q <= 2'b10;
          alu_src_b_q <= 2'b01;
        end
        S_MEMREAD:  adr_src_q <= 1'b1;
        S_MEMWRITE: begin
          adr_src_q   <= 1'b1;
          mem_write_q <= 1'b1;
        end
        S_MEMWB: begin
          result_src_q <= 2'b01;
          reg_write_q  <= 1'b1;
        end
        S_EXECR: begin
          alu_src_a_q <= 2'b10;
          alu_ctrl_q  <= alu_dec;
        end
        S_EXECI: begin
          alu_src_a_q <= 2'b10;
          alu_src_b_q <= 2'b01;
          alu_ctrl_q  <= alu_dec;
        end
        S_ALUWB:  reg_write_q <= 1'b1;
        S_BRANCH: begin
          alu_src_a_q <= 2'b10;
          alu_ctrl_q  <= ALU_SUB;
        end
        S_JAL: begin
          alu_src_a_q <= 2'b01;
          alu_src_b_q <= 2'b10;
        end
        S_TRAP:   illegal_q <= 1'b1;
        default:  illegal_q <= 1'b1;
      endcase
    end
  end

  always_comb begin
    ImmSrc = 2'b00;
    case (opcode)
      OP_STORE:  ImmSrc = 2'b01;
      OP_BRANCH: ImmSrc = 2'b10;
      OP_JAL:    ImmSrc = 2'b11;
      default:   ImmSrc = 2'b00;
    endcase
  end

  // Strobes that depend on this cycle's handshake or flags, all forced low while reset is high.
  assign IRWrite  = ~reset & (state_q == S_FETCH) & mem_ok;
  assign PCWrite  = ~reset & (((state_q == S_FETCH) & mem_ok) |
                              (state_q == S_JAL) |
                              ((state_q == S_BRANCH) & branch_taken & ~branch_trap));
  assign RegWrite = ~reset & reg_write_q;
  assign MemWrite = ~reset & mem_write_q;

  assign AdrSrc     = adr_src_q;
  assign ResultSrc  = result_src_q;
  assign ALUSrcA    = alu_src_a_q;
  assign ALUSrcB    = alu_src_b_q;
  assign ALUControl = alu_ctrl_q;
  assign illegal    = illegal_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed vector table, reset/trap sequences, random instructions.
module tb_multicycle_controller;
  localparam int W = 3;
`ifdef BRANCH_EXT_EN
  localparam bit EXT = 1'b1;
`else
  localparam bit EXT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   Instr;
  logic          Zero, Negative, Overflow, Carry, mem_ready;
  logic          PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
  logic [1:0]    ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [W-1:0]  ALUControl;
  logic [3:0]    state_o;

  int errors = 0;
  int checks = 0;
  int mq[$];

  always #5 clk = ~clk;

  multicycle_controller #(.ALU_CTRL_W(W), .MEM_HS(1)) dut (
    .clk(clk), .reset(reset), .Instr(Instr), .Zero(Zero), .Negative(Negative),
    .Overflow(Overflow), .Carry(Carry), .mem_ready(mem_ready), .PCWrite(PCWrite),
    .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
    .ALUControl(ALUControl), .state_o(state_o), .illegal(illegal)
  );

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [31:0] ins;
    bit          z;
    logic [63:0] tr;
    int          len;
    int          regw, memw, pcw;
    bit          chk_alu;
    logic [2:0]  alu;
    logic [1:0]  imm;
  } vec_t;

  function automatic vec_t mk(logic [31:0] ins, bit z, logic [63:0] tr, int len, int regw, int memw,
                              int pcw, bit ca, logic [2:0] alu, logic [1:0] imm);
    vec_t v;
    v.ins = ins; v.z = z; v.tr = tr; v.len = len; v.regw = regw; v.memw = memw; v.pcw = pcw;
    v.chk_alu = ca; v.alu = alu; v.imm = imm;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: instruction-level rules from the controller's contract.
  function automatic bit alu_legal(logic [2:0] f3);
    return (f3 == 3'b000) || (f3 == 3'b010) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

  function automatic logic [2:0] alu_expect(logic [31:0] ins);
    case (ins[14:12])
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return (ins[6:0] == 7'h33 && ins[30]) ? 3'b001 : 3'b000;
    endcase
  endfunction

  function automatic logic [1:0] imm_expect(logic [6:0] op);
    case (op)
      7'h23:   return 2'b01;
      7'h63:   return 2'b10;
      7'h6F:   return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  function automatic bit taken(logic [2:0] f3, bit z, bit n, bit v, bit c);
    if (!EXT) return z;
    case (f3)
      3'b000:  return z;
      3'b001:  return !z;
      3'b100:  return n ^ v;
      3'b101:  return !(n ^ v);
      3'b110:  return !c;
      3'b111:  return c;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model(input logic [31:0] ins, input bit z, n, v, c, input int fw, mw,
                       output int regw, output int memw, output int pcw);
    logic [6:0] op;
    logic [2:0] f3;
    op = ins[6:0];
    f3 = ins[14:12];
    mq.delete();
    regw = 0; memw = 0; pcw = 1;
    repeat (fw + 1) mq.push_back(0);
    mq.push_back(1);
    case (op)
      7'h03: begin
        mq.push_back(2);
        repeat (mw + 1) mq.push_back(3);
        mq.push_back(4);
        regw = 1;
      end
      7'h23: begin
        mq.push_back(2);
        repeat (mw + 1) mq.push_back(5);
        memw = mw + 1;
      end
      7'h33, 7'h13: begin
        mq.push_back(op == 7'h33 ? 6 : 7);
        if (alu_legal(f3)) begin
          mq.push_back(8);
          regw = 1;
        end else begin
          mq.push_back(11);
        end
      end
      7'h63: begin
        mq.push_back(9);
        if (EXT && (f3 == 3'b010 || f3 == 3'b011)) mq.push_back(11);
        else if (taken(f3, z, n, v, c)) pcw = 2;
      end
      7'h6F: begin
        mq.push_back(10);
        mq.push_back(8);
        regw = 1;
        pcw = 2;
      end
      default: mq.push_back(11);
    endcase
  endtask

  // Drives one instruction along the given state trace; mem_ready completes memory waits on the
  // last cycle of each FETCH/MEMREAD/MEMWRITE run and is random elsewhere.
  task automatic run(input logic [31:0] ins, input bit z, n, v, c, input int tr[$],
                     output int regw, output int memw, output int pcw, output int irw,
                     output bit trace_ok, output logic [2:0] alu_obs, output logic [1:0] imm_obs);
    regw = 0; memw = 0; pcw = 0; irw = 0; trace_ok = 1'b1; alu_obs = '0; imm_obs = '0;
    Instr = ins; Zero = z; Negative = n; Overflow = v; Carry = c;
    for (int i = 0; i < tr.size(); i++) begin
      if (tr[i] == 0 || tr[i] == 3 || tr[i] == 5)
        mem_ready = (i == tr.size() - 1) ? 1'b1 : (tr[i+1] != tr[i]);
      else
        mem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (int'(state_o) != tr[i]) trace_ok = 1'b0;
      regw += int'(RegWrite);
      memw += int'(MemWrite);
      pcw  += int'(PCWrite);
      irw  += int'(IRWrite);
      if (state_o == 4'd6 || state_o == 4'd7) alu_obs = ALUControl;
      if (state_o == 4'd1) imm_obs = ImmSrc;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    mem_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    check("reset_enables", {28'd0, PCWrite, IRWrite, RegWrite, MemWrite}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic trap_hold();
    for (int k = 0; k < 3; k++) begin
      mem_ready = 1'b1;
      @(negedge clk);
      check("trap_hold", {state_o, illegal, PCWrite, IRWrite, RegWrite, MemWrite},
            {4'd11, 1'b1, 4'b0000});
      @(posedge clk);
      #1;
    end
    do_reset();
  endtask

  vec_t vecs[13];

  initial begin
    int         regw, memw, pcw, irw, er, em, ep, tq[$];
    bit         tok;
    logic [2:0] alu_obs;
    logic [1:0] imm_obs;

    vecs[0]  = mk(32'h00412083, 1'b0, 64'h43210,     5, 1, 0, 1, 1'b0, 3'b000, 2'b00);
    vecs[1]  = mk(32'h00112223, 1'b0, 64'h5555210,   7, 0, 4, 1, 1'b0, 3'b000, 2'b01);
    vecs[2]  = mk(32'h40208033, 1'b0, 64'h8610,      4, 1, 0, 1, 1'b1, 3'b001, 2'b00);
    vecs[3]  = mk(32'h00508093, 1'b0, 64'h8710,      4, 1, 0, 1, 1'b1, 3'b000, 2'b00);
    vecs[4]  = mk(32'h00208463, 1'b1, 64'h910,       3, 0, 0, 2, 1'b0, 3'b000, 2'b10);
    vecs[5]  = mk(32'h00208463, 1'b0, 64'h910,       3, 0, 0, 1, 1'b0, 3'b000, 2'b10);
    vecs[6]  = mk(32'h00209463, 1'b0, 64'h910,       3, 0, 0, EXT ? 2 : 1, 1'b0, 3'b000, 2'b10);
    vecs[7]  = mk(32'h008000EF, 1'b0, 64'h8A10,      4, 1, 0, 2, 1'b0, 3'b000, 2'b11);
    vecs[8]  = mk(32'h00412083, 1'b0, 64'h433321000, 9, 1, 0, 1, 1'b0, 3'b000, 2'b00);
    vecs[9]  = mk(32'h0020E0B3, 1'b0, 64'h8610,      4, 1, 0, 1, 1'b1, 3'b011, 2'b00);
    vecs[10] = mk(32'h0020A093, 1'b0, 64'h8710,      4, 1, 0, 1, 1'b1, 3'b101, 2'b00);
    vecs[11] = mk(32'h002090B3, 1'b0, 64'hB610,      4, 0, 0, 1, 1'b0, 3'b000, 2'b00);
    vecs[12] = mk(32'h0000007F, 1'b0, 64'hB10,       3, 0, 0, 1, 1'b0, 3'b000, 2'b00);

    reset = 1'b1; Instr = 32'h0; Zero = 1'b0; Negative = 1'b0; Overflow = 1'b0; Carry = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
    check("reset_cycle_enables", {28'd0, PCWrite, IRWrite, RegWrite, MemWrite}, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
    check("post_reset_state", 32'(state_o), 32'd0);
    check("post_reset_illegal", 32'(illegal), 32'd0);
    check("fetch_mux", {26'd0, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc[0]}, {26'd0, 1'b0, 2'b00, 2'b10, 1'b0});
    check("fetch_resultsrc", 32'(ResultSrc), 32'd2);
    check("fetch_aluctrl", 32'(ALUControl), 32'd0);
    check("fetch_wait_strobes", {30'd0, IRWrite, PCWrite}, 32'd0);
    @(posedge clk); #1;

    // Directed vector table.
    for (int t = 0; t < 13; t++) begin
      tq.delete();
      for (int k = 0; k < vecs[t].len; k++) tq.push_back(int'(vecs[t].tr[4*k +: 4]));
      run(vecs[t].ins, vecs[t].z, 1'b0, 1'b0, 1'b1, tq, regw, memw, pcw, irw, tok, alu_obs, imm_obs);
      $display("vec %0d instr=%08h cycles=%0d regw=%0d memw=%0d pcw=%0d", t, vecs[t].ins,
               vecs[t].len, regw, memw, pcw);
      check($sformatf("vec%0d_trace", t), 32'(tok), 32'd1);
      check($sformatf("vec%0d_regwrite", t), regw, vecs[t].regw);
      check($sformatf("vec%0d_memwrite", t), memw, vecs[t].memw);
      check($sformatf("vec%0d_pcwrite", t), pcw, vecs[t].pcw);
      check($sformatf("vec%0d_irwrite", t), irw, 1);
      check($sformatf("vec%0d_immsrc", t), 32'(imm_obs), 32'(vecs[t].imm));
      if (vecs[t].chk_alu) check($sformatf("vec%0d_aluctrl", t), 32'(alu_obs), 32'(vecs[t].alu));
      if (tq[tq.size()-1] == 11) trap_hold();
    end

    // Reset asserted while MEMREAD is waiting on memory.
    Instr = 32'h00412083;
    mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    check("memread_wait_state", 32'(state_o), 32'd3);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("memread_reset_enables", {28'd0, PCWrite, IRWrite, RegWrite, MemWrite}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("memread_reset_to_fetch", 32'(state_o), 32'd0);
    check("memread_reset_no_regwrite", 32'(RegWrite), 32'd0);
    @(posedge clk); #1;

    // Random instructions against the model.
    for (int t = 0; t < 150; t++) begin
      logic [31:0] ins;
      bit          z, n, v, c;
      int          fw, mw, sel;
      logic [6:0]  ops [7];
      ops = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F, 7'h00};
      ins = $urandom;
      sel = $urandom_range(0, 6);
      ins[6:0] = (sel == 6) ? 7'($urandom) : ops[sel];
      z = 1'($urandom); n = 1'($urandom); v = 1'($urandom); c = 1'($urandom);
      fw = $urandom_range(0, 2);
      mw = $urandom_range(0, 3);
      model(ins, z, n, v, c, fw, mw, er, em, ep);
      run(ins, z, n, v, c, mq, regw, memw, pcw, irw, tok, alu_obs, imm_obs);
      $display("rnd %0d instr=%08h cycles=%0d regw=%0d memw=%0d pcw=%0d", t, ins, mq.size(),
               regw, memw, pcw);
      check("rnd_trace", 32'(tok), 32'd1);
      check("rnd_regwrite", regw, er);
      check("rnd_memwrite", memw, em);
      check("rnd_pcwrite", pcw, ep);
      check("rnd_irwrite", irw, 1);
      check("rnd_immsrc", 32'(imm_obs), 32'(imm_expect(ins[6:0])));
      if ((ins[6:0] == 7'h33 || ins[6:0] == 7'h13) && alu_legal(ins[14:12]))
        check("rnd_aluctrl", 32'(alu_obs), 32'(alu_expect(ins)));
      if (mq[mq.size()-1] == 11) trap_hold();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
